// File: rtl/disp_dither.sv
// Ordered 4x4 Bayer dither from 12-bit linear RGB to 8-bit panel RGB,
// with optional per-frame matrix rotation and a fixed two-cycle latency.
module disp_dither #(
  parameter int unsigned IN_DW   = 12,
  parameter int unsigned OUT_DW  = 8,
  parameter int unsigned HCNT_BW = 11,
  parameter int unsigned VCNT_BW = 11
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic [IN_DW-1:0]  r_in,
  input  logic [IN_DW-1:0]  g_in,
  input  logic [IN_DW-1:0]  b_in,
  input  logic              reg_dither_en,
  input  logic              reg_temporal_en,
  output logic              vsync_out,
  output logic              de_out,
  output logic [OUT_DW-1:0] r_out,
  output logic [OUT_DW-1:0] g_out,
  output logic [OUT_DW-1:0] b_out
);

  localparam int unsigned FRAC_W = IN_DW - OUT_DW;
  localparam int unsigned SUM_W  = OUT_DW + 1;

  logic               vsync_d1, de_d1;
  logic               vs_rise, de_fall;
  logic               dith_en_s, temp_en_s;
  logic [HCNT_BW-1:0] h_cnt;
  logic [VCNT_BW-1:0] v_cnt;
  logic [1:0]         frm_cnt;
  logic [1:0]         f, xi, yi;
  logic [FRAC_W-1:0]  thr;

  logic [IN_DW-1:0]   r_s1, g_s1, b_s1;
  logic               vs_s1, de_s1, dith_s1;
  logic [FRAC_W-1:0]  thr_s1;

  // Round up by one LSB when the dropped fraction exceeds the threshold.
  function automatic logic [OUT_DW-1:0] dither_ch(input logic [IN_DW-1:0]  px,
                                                  input logic [FRAC_W-1:0] t,
                                                  input logic              en);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(px[IN_DW-1:FRAC_W]) + SUM_W'(en && (px[FRAC_W-1:0] > t));
    return sum[OUT_DW] ? {OUT_DW{1'b1}} : sum[OUT_DW-1:0];
  endfunction

  // Edge detects and threshold lookup for the pixel currently at the input.
  always_comb begin
    vs_rise = vsync_in & ~vsync_d1;
    de_fall = ~de_in & de_d1;
    f       = temp_en_s ? frm_cnt : 2'd0;
    xi      = h_cnt[1:0] + f;
    yi      = v_cnt[1:0] + {f[0], f[1]};
    thr     = '0;
    case ({yi, xi})
      4'h0: thr = FRAC_W'(0);
      4'h1: thr = FRAC_W'(8);
      4'h2: thr = FRAC_W'(2);
      4'h3: thr = FRAC_W'(10);
      4'h4: thr = FRAC_W'(12);
      4'h5: thr = FRAC_W'(4);
      4'h6: thr = FRAC_W'(14);
      4'h7: thr = FRAC_W'(6);
      4'h8: thr = FRAC_W'(3);
      4'h9: thr = FRAC_W'(11);
      4'hA: thr = FRAC_W'(1);
      4'hB: thr = FRAC_W'(9);
      4'hC: thr = FRAC_W'(15);
      4'hD: thr = FRAC_W'(7);
      4'hE: thr = FRAC_W'(13);
      4'hF: thr = FRAC_W'(5);
      default: thr = '0;
    endcase
  end

  // Position tracking and frame-start shadowing of the control bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_d1  <= 1'b0;
      de_d1     <= 1'b0;
      dith_en_s <= 1'b0;
      temp_en_s <= 1'b0;
      frm_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
    end else begin
      vsync_d1 <= vsync_in;
      de_d1    <= de_in;
      if (vs_rise) begin
        dith_en_s <= reg_dither_en;
        temp_en_s <= reg_temporal_en;
        frm_cnt   <= frm_cnt + 2'd1;
      end
      h_cnt <= de_in ? h_cnt + HCNT_BW'(1) : '0;
      if (vs_rise)      v_cnt <= '0;
      else if (de_fall) v_cnt <= v_cnt + VCNT_BW'(1);
    end
  end

  // Stage 1: capture pixel, timing and its threshold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1    <= '0;
      g_s1    <= '0;
      b_s1    <= '0;
      vs_s1   <= 1'b0;
      de_s1   <= 1'b0;
      dith_s1 <= 1'b0;
      thr_s1  <= '0;
    end else begin
      r_s1    <= r_in;
      g_s1    <= g_in;
      b_s1    <= b_in;
      vs_s1   <= vsync_in;
      de_s1   <= de_in;
      dith_s1 <= dith_en_s;
      thr_s1  <= thr;
    end
  end

  // Stage 2: add, saturate and blank outside active video.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else begin
      vsync_out <= vs_s1;
      de_out    <= de_s1;
      r_out     <= de_s1 ? dither_ch(r_s1, thr_s1, dith_s1) : '0;
      g_out     <= de_s1 ? dither_ch(g_s1, thr_s1, dith_s1) : '0;
      b_out     <= de_s1 ? dither_ch(b_s1, thr_s1, dith_s1) : '0;
    end
  end

endmodule

// File: tb/tb_disp_dither.sv
// Directed bench for disp_dither: reset, truncation, Bayer tile, saturation,
// bypass, mid-frame shadowing and temporal rotation with hand-computed outputs.
module tb_disp_dither;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vsync_in, de_in;
  logic [11:0] r_in, g_in, b_in;
  logic        reg_dither_en, reg_temporal_en;
  logic        vsync_out, de_out;
  logic [7:0]  r_out, g_out, b_out;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected outputs for the pixel driven on the previous cycle.
  logic       pv_vs, pv_de;
  logic [7:0] pv_r, pv_g, pv_b;

  disp_dither dut (
    .clk             (clk),
    .rstn            (rstn),
    .vsync_in        (vsync_in),
    .de_in           (de_in),
    .r_in            (r_in),
    .g_in            (g_in),
    .b_in            (b_in),
    .reg_dither_en   (reg_dither_en),
    .reg_temporal_en (reg_temporal_en),
    .vsync_out       (vsync_out),
    .de_out          (de_out),
    .r_out           (r_out),
    .g_out           (g_out),
    .b_out           (b_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %02h expected %02h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_all(input logic vs, input logic de,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    chk("vsync_out", 8'(vsync_out), 8'(vs));
    chk("de_out",    8'(de_out),    8'(de));
    chk("r_out",     r_out,         er);
    chk("g_out",     g_out,         eg);
    chk("b_out",     b_out,         eb);
  endtask

  // Drive one pixel, advance a clock, check the pixel driven two edges earlier.
  task automatic px(input logic vs, input logic de,
                    input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                    input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    vsync_in = vs;
    de_in    = de;
    r_in     = r;
    g_in     = g;
    b_in     = b;
    @(posedge clk);
    #1;
    chk_all(pv_vs, pv_de, pv_r, pv_g, pv_b);
    pv_vs = vs;
    pv_de = de;
    pv_r  = de ? er : 8'h00;
    pv_g  = de ? eg : 8'h00;
    pv_b  = de ? eb : 8'h00;
  endtask

  // Four active pixels then one blanking cycle with non-zero data.
  task automatic line4(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                       input logic [31:0] er, input logic [31:0] eg, input logic [31:0] eb);
    for (int i = 0; i < 4; i++)
      px(1'b0, 1'b1, r, g, b, er[31-8*i -: 8], eg[31-8*i -: 8], eb[31-8*i -: 8]);
    px(1'b0, 1'b0, 12'h5A5, 12'hA5A, 12'hFFF, 8'h00, 8'h00, 8'h00);
  endtask

  // Vsync held high for two cycles: a single frame start.
  task automatic vs_pulse();
    px(1'b1, 1'b0, 12'h111, 12'h222, 12'h333, 8'h00, 8'h00, 8'h00);
    px(1'b1, 1'b0, 12'h111, 12'h222, 12'h333, 8'h00, 8'h00, 8'h00);
    px(1'b0, 1'b0, 12'h111, 12'h222, 12'h333, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    // Reset held with live stimulus: everything stays at zero
    rstn            = 1'b0;
    vsync_in        = 1'b1;
    de_in           = 1'b1;
    r_in            = 12'hFFF;
    g_in            = 12'hFFF;
    b_in            = 12'hFFF;
    reg_dither_en   = 1'b1;
    reg_temporal_en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
    vsync_in = 1'b0;
    de_in    = 1'b0;
    rstn     = 1'b1;
    pv_vs = 1'b0; pv_de = 1'b0; pv_r = 8'h00; pv_g = 8'h00; pv_b = 8'h00;

    // No frame start yet: truncation even though dither is requested
    px(1'b0, 1'b1, 12'h808, 12'h80F, 12'hFFF, 8'h80, 8'h80, 8'hFF);
    px(1'b0, 1'b1, 12'h80F, 12'h00F, 12'hABC, 8'h80, 8'h00, 8'hAB);
    px(1'b0, 1'b0, 12'h123, 12'h456, 12'h789, 8'h00, 8'h00, 8'h00);

    // Frame A (frm_cnt=1), dither on, temporal off: full 4x4 tile
    vs_pulse();
    line4(12'h808, 12'h00F, 12'hFFF, 32'h81808180, 32'h01010101, 32'hFFFFFFFF);
    line4(12'h808, 12'h00F, 12'hFFF, 32'h80818081, 32'h01010101, 32'hFFFFFFFF);
    line4(12'h808, 12'h00F, 12'hFFF, 32'h81808180, 32'h01010101, 32'hFFFFFFFF);
    line4(12'h808, 12'h00F, 12'hFFF, 32'h80818081, 32'h00010101, 32'hFFFFFFFF);
    line4(12'h000, 12'hABC, 12'h7F8, 32'h00000000, 32'hACACACAC, 32'h807F807F);

    // Mid-frame disable is ignored until the next frame start
    reg_dither_en = 1'b0;
    line4(12'h808, 12'h00F, 12'hFFF, 32'h80818081, 32'h01010101, 32'hFFFFFFFF);

    // Frame B (frm_cnt=2): bypass truncation
    vs_pulse();
    line4(12'hABC, 12'h80F, 12'h00F, 32'hABABABAB, 32'h80808080, 32'h00000000);

    // Frame C (frm_cnt=3), temporal on: thresholds 5,15,7,13 on line 0
    reg_dither_en   = 1'b1;
    reg_temporal_en = 1'b1;
    vs_pulse();
    line4(12'h808, 12'h80C, 12'h80E, 32'h81808180, 32'h81808180, 32'h81808181);

    // Frame D (frm_cnt wrapped to 0): thresholds 0,8,2,10
    vs_pulse();
    line4(12'h808, 12'h80C, 12'h80E, 32'h81808180, 32'h81818181, 32'h81818181);

    // Frame E (frm_cnt=1): thresholds 11,1,9,3
    vs_pulse();
    line4(12'h808, 12'h80C, 12'h80E, 32'h80818081, 32'h81818181, 32'h81818181);

    px(1'b0, 1'b0, 12'h000, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_dither.md
# disp_dither

Spatial/temporal dither stage directly downstream of the de-gamma block: reduces 12-bit linear RGB to 8-bit panel RGB with a 4x4 ordered (Bayer) threshold matrix, optionally rotated per frame. It derives pixel, line and frame position from the incoming vsync/de timing. It emits a fixed-latency, re-timed vsync/de/RGB stream toward the panel interface.

## Interface
- IN_DW, 12, input component width; IN_DW-OUT_DW is fixed at 4
- OUT_DW, 8, output component width
- HCNT_BW, 11, pixel counter width
- VCNT_BW, 11, line counter width
- clk  input  1  pixel clock, single clock domain
- rstn  input  1  asynchronous, active-low reset
- vsync_in  input  1  frame sync, active high
- de_in  input  1  data enable, active high
- r_in / g_in / b_in  input  IN_DW each  linear component
- reg_dither_en  input  1  dither enable (shadowed at frame start)
- reg_temporal_en  input  1  per-frame matrix rotation enable (shadowed at frame start)
- vsync_out  output  1  vsync_in delayed 2 cycles
- de_out  output  1  de_in delayed 2 cycles
- r_out / g_out / b_out  output  OUT_DW each  dithered component

## Operation
- vs_rise = vsync_in & ~vsync_in_d1; de_fall = ~de_in & de_in_d1.
- Shadow registers dith_en_s, temp_en_s load reg_dither_en / reg_temporal_en on vs_rise only; mid-frame register changes have no effect until the next vs_rise.
- h_cnt: 0 while de_in low; +1 each cycle de_in high (first active pixel uses h_cnt=0); wraps mod 2^HCNT_BW.
- v_cnt: cleared on vs_rise; +1 on de_fall; vs_rise has priority over a coincident de_fall; wraps mod 2^VCNT_BW.
- frm_cnt (2 bits): +1 on vs_rise, wraps 3->0.
- Matrix coordinates: xi = (h_cnt[1:0] + f[1:0]) mod 4; yi = (v_cnt[1:0] + {f[0],f[1]}) mod 4; f = temp_en_s ? frm_cnt : 0. Coordinates use counter values for the current pixel.
- Threshold T(yi,xi), row-major: row0 0,8,2,10; row1 12,4,14,6; row2 3,11,1,9; row3 15,7,13,5.
- Same T applies to all three channels.
- Per channel, dith_en_s=1: out = in[11:4] + (in[3:0] > T ? 1 : 0), computed 9 bits wide, saturated to 255.
- dith_en_s=0: out = in[11:4] (truncation), same latency.
- Pixel outputs are forced to 0 on cycles where the delayed de (de_out) is low.

## Timing
- Stage 1 registers: input data, vsync, de, and the 4-bit T.
- Stage 2 registers: add, saturate, blank; drives outputs.
- Total latency is 2 cycles for all outputs, regardless of enable state. All outputs are registered.
- Reset values: vsync_out=0, de_out=0, r_out=g_out=b_out=0. h_cnt, v_cnt, frm_cnt, dith_en_s, temp_en_s and all pipeline registers reset to 0.
- Reset mid-frame: the block runs in truncation mode, position 0, until the next vs_rise, which loads the enables and sets frm_cnt=1.
- No back-pressure: one pixel accepted every cycle, unconditionally.
- vsync_in held high for several cycles counts as one vs_rise.
- de_in high across vs_rise: h_cnt continues; v_cnt restarts at 0.

## Test plan
- Reset: assert rstn=0 with active stimulus -> all outputs 0. After release, with no vs_rise yet, in 0x808 -> out 0x80 at 2-cycle latency.
- Flat field 0x808, dither on, temporal off, after vs_rise -> line 0 outputs 0x81,0x80,0x81,0x80 repeating. Each 4x4 tile has exactly 8 pixels of 0x81.
- Saturation/floor: in 0xFFF -> 0xFF at every position. In 0x000 -> 0x00 at every position. In 0x00F -> 0x01 everywhere except T=15 positions (0x00).
- Bypass: reg_dither_en=0 at vs_rise, in 0xABC -> 0xAB. vsync_out/de_out match inputs delayed exactly 2 cycles.
- Temporal: temporal on, in 0x808; pixel (0,0) -> frame with frm_cnt=0 gives 0x81 (T=0), frm_cnt=1 gives 0x80 (T=11). frm_cnt wraps after 4 vs_rise.
- Mid-frame register change: toggle reg_dither_en 1->0 at line 10 -> output unchanged for the rest of the frame; truncation takes effect from the next vs_rise.
